// File: rtl/vdec_hs_sbfetch_if.sv
// DIRAM read port and soft-bit pair stream between the fetch stage and its neighbours.
interface vdec_hs_sbfetch_if #(
    parameter int unsigned ADDR_W = 9
);
    localparam int unsigned WORD_W = 24;
    localparam int unsigned PAIR_W = 12;

    logic              diram_rd_req;
    logic [ADDR_W-1:0] diram_rd_addr;
    logic              diram_rd_ack;
    logic [WORD_W-1:0] diram_dout;
    logic              sb_valid;
    logic [PAIR_W-1:0] sb_data;
    logic              sb_last;
    logic              sb_ready;

    modport master (
        output diram_rd_req, diram_rd_addr, sb_valid, sb_data, sb_last,
        input  diram_rd_ack, diram_dout, sb_ready
    );

    modport slave (
        input  diram_rd_req, diram_rd_addr, sb_valid, sb_data, sb_last,
        output diram_rd_ack, diram_dout, sb_ready
    );
endinterface

// File: rtl/vdec_hs_sbfetch.sv
// Soft-bit fetch: reads packed 24-bit CRAM words into a small FIFO and streams
// 12-bit soft-bit pairs to the HS Viterbi decoder through a registered output stage.
module vdec_hs_sbfetch #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    vdec_hs_sbfetch_if.master bus
);
    localparam int unsigned WORD_W = 24;
    localparam int unsigned PAIR_W = 12;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

    state_e                               state_q, state_d;
    logic                                 req_q, req_d;
    logic [ADDR_W-1:0]                    addr_q, addr_d;
    logic [ADDR_W-1:0]                    ack_cnt_q, ack_cnt_d;
    logic [ADDR_W-1:0]                    pop_cnt_q, pop_cnt_d;
    logic [ADDR_W-1:0]                    last_idx_q, last_idx_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic [FIFO_DEPTH-1:0][WORD_W-1:0]    mem_q, mem_d;
    logic [PTR_W-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 half_q, half_d;
    logic                                 sb_valid_q, sb_valid_d;
    logic [PAIR_W-1:0]                    sb_data_q, sb_data_d;
    logic                                 sb_last_q, sb_last_d;

    logic              push;
    logic              load;
    logic              pop;
    logic [WORD_W-1:0] head;

    assign head = mem_q[rd_ptr_q];

    // Next-state: FIFO bookkeeping, output-stage refill, then control FSM; abort overrides all.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        ack_cnt_d  = ack_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        last_idx_d = last_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        sb_valid_d = sb_valid_q;
        sb_data_d  = sb_data_q;
        sb_last_d  = sb_last_q;

        push = (state_q == FETCH) && req_q && bus.diram_rd_ack;
        load = (cnt_q != '0) && (!sb_valid_q || bus.sb_ready);
        pop  = load && half_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.diram_dout;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            pop_cnt_d = pop_cnt_q + ADDR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        // Output register refills whenever it is empty or being handshaken this cycle.
        if (load) begin
            sb_valid_d = 1'b1;
            sb_data_d  = half_q ? head[WORD_W-1:PAIR_W] : head[PAIR_W-1:0];
            sb_last_d  = half_q && (pop_cnt_q == last_idx_q);
            half_d     = ~half_q;
        end else if (sb_valid_q && bus.sb_ready) begin
            sb_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        busy_d     = 1'b1;
                        req_d      = 1'b1;
                        addr_d     = base_addr;
                        last_idx_d = num_words - ADDR_W'(1);
                        ack_cnt_d  = '0;
                        pop_cnt_d  = '0;
                        half_d     = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (push) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    ack_cnt_d = ack_cnt_q + ADDR_W'(1);
                    if (ack_cnt_q == last_idx_q) begin
                        state_d = DRAIN;
                        req_d   = 1'b0;
                    end else begin
                        req_d = (cnt_d < DEPTH_C);
                    end
                end else if (!req_q) begin
                    req_d = (cnt_d < DEPTH_C);
                end
            end
            DRAIN: begin
                if (sb_valid_q && bus.sb_ready && sb_last_q) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    sb_last_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            req_d      = 1'b0;
            addr_d     = '0;
            ack_cnt_d  = '0;
            pop_cnt_d  = '0;
            last_idx_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            half_d     = 1'b0;
            sb_valid_d = 1'b0;
            sb_data_d  = '0;
            sb_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            ack_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            last_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            half_q     <= 1'b0;
            sb_valid_q <= 1'b0;
            sb_data_q  <= '0;
            sb_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            ack_cnt_q  <= ack_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            last_idx_q <= last_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            sb_valid_q <= sb_valid_d;
            sb_data_q  <= sb_data_d;
            sb_last_q  <= sb_last_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign bus.diram_rd_req  = req_q;
    assign bus.diram_rd_addr = addr_q;
    assign bus.sb_valid      = sb_valid_q;
    assign bus.sb_data       = sb_data_q;
    assign bus.sb_last       = sb_last_q;

endmodule

// File: tb/tb_vdec_hs_sbfetch.sv
// Directed bench for vdec_hs_sbfetch: DIRAM responder with programmable ack latency,
// controllable sink, negedge monitor logging acks/pairs and hold-stability.
module tb_vdec_hs_sbfetch;
    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              res = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] num_words = '0;
    logic              busy;
    logic              done;

    vdec_hs_sbfetch_if #(.ADDR_W(ADDR_W)) bus ();

    vdec_hs_sbfetch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int   ack_lat = 0;
    int   wait_cnt = 0;
    logic sb_ready_tb = 1'b1;
    int   cyc = 0;

    // CRAM model: word content derived from its address so halves are distinguishable.
    assign bus.diram_rd_ack = bus.diram_rd_req && (wait_cnt == ack_lat);
    assign bus.diram_dout   = {3'h5, bus.diram_rd_addr, 3'h3, bus.diram_rd_addr};
    assign bus.sb_ready     = sb_ready_tb;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bus.diram_rd_req || bus.diram_rd_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [ADDR_W-1:0] ack_q[$];
    logic [12:0]       pair_q[$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    logic              hold_v = 1'b0;
    logic              hold_r = 1'b0;
    logic [12:0]       hold_pair = '0;
    logic [ADDR_W-1:0] hold_addr = '0;

    always @(negedge clk) begin
        if (hold_v)
            check("sb_hold", 32'({bus.sb_valid, bus.sb_last, bus.sb_data}), 32'({1'b1, hold_pair}));
        if (hold_r)
            check("addr_hold", 32'({bus.diram_rd_req, bus.diram_rd_addr}), 32'({1'b1, hold_addr}));
        if (bus.diram_rd_req && bus.diram_rd_ack) ack_q.push_back(bus.diram_rd_addr);
        if (bus.sb_valid && bus.sb_ready) pair_q.push_back({bus.sb_last, bus.sb_data});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        hold_v    = res && !abort && bus.sb_valid && !bus.sb_ready;
        hold_pair = {bus.sb_last, bus.sb_data};
        hold_r    = res && !abort && bus.diram_rd_req && !bus.diram_rd_ack;
        hold_addr = bus.diram_rd_addr;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_q.delete();
        pair_q.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n, output int t);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        t         = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_cnt != d0) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'(0), 32'(1));
    endtask

    function automatic logic [12:0] exp_pair(input logic [ADDR_W-1:0] b, input int n, input int p);
        int                w;
        logic [ADDR_W-1:0] a;
        logic              hi;
        w  = p / 2;
        a  = ADDR_W'(b + ADDR_W'(w));
        hi = (p % 2) == 1;
        return {hi && (w == n - 1), hi ? {3'h5, a} : {3'h3, a}};
    endfunction

    task automatic check_block(input logic [ADDR_W-1:0] b, input int n);
        check("ack_count", ack_q.size(), n);
        for (int w = 0; w < n; w++)
            if (w < ack_q.size()) check("ack_addr", 32'(ack_q[w]), 32'(ADDR_W'(b + ADDR_W'(w))));
        check("pair_count", pair_q.size(), 2 * n);
        for (int p = 0; p < 2 * n; p++)
            if (p < pair_q.size()) check("pair", 32'(pair_q[p]), 32'(exp_pair(b, n, p)));
    endtask

    int t0;
    int d_before;

    initial begin
        res = 1'b0;
        tick(3);
        check("rst_ctrl", 32'({busy, done, bus.diram_rd_req, bus.sb_valid, bus.sb_last}), 32'(0));
        check("rst_addr", 32'(bus.diram_rd_addr), 32'(0));
        check("rst_data", 32'(bus.sb_data), 32'(0));
        res = 1'b1;
        tick();

        // Basic block, zero-wait DIRAM and sink
        clear_logs();
        pulse_start(9'h010, 9'd3, t0);
        check("start_busy_req", 32'({busy, bus.diram_rd_req}), 32'(2'b11));
        check("start_addr", 32'(bus.diram_rd_addr), 32'(9'h010));
        wait_done(50);
        check_block(9'h010, 3);
        check("basic_latency", done_cyc - t0, 9);
        check("basic_busy_after", 32'(busy), 32'(0));

        // Address wrap
        tick(2);
        clear_logs();
        pulse_start(9'h1FE, 9'd4, t0);
        wait_done(50);
        check_block(9'h1FE, 4);
        check("wrap_latency", done_cyc - t0, 11);

        // Backpressure from the first pair
        tick(2);
        clear_logs();
        sb_ready_tb = 1'b0;
        pulse_start(9'h040, 9'd8, t0);
        for (int i = 0; i < 20 && !bus.sb_valid; i++) tick();
        check("bp_valid_seen", 32'(bus.sb_valid), 32'(1));
        tick(20);
        check("bp_ack_count", ack_q.size(), 4);
        check("bp_req_low", 32'(bus.diram_rd_req), 32'(0));
        check("bp_no_pairs", pair_q.size(), 0);
        sb_ready_tb = 1'b1;
        wait_done(200);
        check_block(9'h040, 8);

        // Slow DIRAM
        tick(2);
        clear_logs();
        ack_lat = 5;
        d_before = done_cnt;
        pulse_start(9'h100, 9'd3, t0);
        wait_done(200);
        check_block(9'h100, 3);
        check("slow_done_once", done_cnt - d_before, 1);
        ack_lat = 0;

        // Abort coinciding with the ack of word 2 of 8
        tick(2);
        clear_logs();
        pulse_start(9'h080, 9'd8, t0);
        for (int i = 0; i < 20 && !(bus.diram_rd_req && bus.diram_rd_addr == 9'h082); i++) tick();
        check("abort_at_word2", 32'({bus.diram_rd_req, bus.diram_rd_ack, bus.diram_rd_addr}),
              32'({2'b11, 9'h082}));
        d_before = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", 32'({busy, done, bus.diram_rd_req, bus.sb_valid}), 32'(0));
        tick(10);
        check("abort_no_done", done_cnt - d_before, 0);
        clear_logs();
        pulse_start(9'h0C0, 9'd2, t0);
        wait_done(50);
        check_block(9'h0C0, 2);

        // Zero-length block
        tick(2);
        clear_logs();
        pulse_start(9'h055, 9'd0, t0);
        check("zero_done", 32'({done, busy, bus.diram_rd_req}), 32'(3'b100));
        tick();
        check("zero_done_pulse", 32'({done, busy}), 32'(0));
        tick(3);
        check("zero_no_ack", ack_q.size(), 0);

        // Start while busy is ignored
        clear_logs();
        d_before = done_cnt;
        pulse_start(9'h020, 9'd2, t0);
        tick();
        start = 1'b1; base_addr = 9'h1AA; num_words = 9'd5;
        tick();
        start = 1'b0;
        wait_done(50);
        tick(20);
        check_block(9'h020, 2);
        check("busy_start_one_done", done_cnt - d_before, 1);

        // Reset mid-block
        clear_logs();
        d_before = done_cnt;
        pulse_start(9'h030, 9'd8, t0);
        tick(3);
        res = 1'b0;
        tick();
        check("midrst_ctrl", 32'({busy, done, bus.diram_rd_req, bus.sb_valid, bus.sb_last}), 32'(0));
        check("midrst_addr_data", 32'({bus.diram_rd_addr, bus.sb_data}), 32'(0));
        res = 1'b1;
        tick(30);
        check("midrst_no_done", done_cnt - d_before, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
